// File: rtl/disparity_argbest.sv
// disparity_argbest: streaming arg-best over NCAND matching scores per pixel.
// Stage A reduces one beat of LANES scores to a best/second pair, stage B
// folds that pair into the running per-pixel accumulator, and the result is
// presented on a registered valid/ready output with a uniqueness flag.
module disparity_argbest #(
  parameter int SCORE_W = 18,
  parameter int LANES   = 4,
  parameter int NCAND   = 16,
  parameter int IDX_W   = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mode_min,
  input  logic [SCORE_W-1:0]         uniq_margin,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [LANES*SCORE_W-1:0]   s_scores,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [IDX_W-1:0]           m_idx,
  output logic [SCORE_W-1:0]         m_best,
  output logic [SCORE_W-1:0]         m_second,
  output logic                       m_unique
);

  localparam int NBEATS = NCAND / LANES;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {ST_ACCUM = 2'd0, ST_DRAIN = 2'd1, ST_HOLD = 2'd2} state_e;

  // Strictly better: ties never displace the incumbent, so the lower index wins.
  function automatic logic better(input logic [SCORE_W-1:0] a,
                                  input logic [SCORE_W-1:0] b,
                                  input logic               mmin);
    if (mmin) better = (a < b);
    else      better = (a > b);
  endfunction

  // Better of two scores (only the value matters, so tie order is irrelevant).
  function automatic logic [SCORE_W-1:0] pick(input logic [SCORE_W-1:0] a,
                                              input logic [SCORE_W-1:0] b,
                                              input logic               mmin);
    pick = better(b, a, mmin) ? b : a;
  endfunction

  state_e               state_q, state_d;
  logic                 s_ready_q;
  logic [BEAT_W-1:0]    beat_cnt_q;
  logic                 mode_q;
  logic [SCORE_W-1:0]   margin_q;

  logic                 accept_s, last_beat_s, first_beat_s, mode_eff_s;
  logic [IDX_W-1:0]     base_s, bi_s;
  logic [SCORE_W-1:0]   lane_s, bb_s, bs_s;

  logic                 a_vld_q, a_first_q, a_last_q;
  logic [SCORE_W-1:0]   a_best_q, a_sec_q;
  logic [IDX_W-1:0]     a_idx_q;

  logic [SCORE_W-1:0]   acc_best_q, acc_sec_q, nb_s, ns_s;
  logic [IDX_W-1:0]     acc_idx_q, ni_s;
  logic                 b_last_q;

  logic [SCORE_W:0]     diff_s;
  logic                 uniq_s;

  logic                 m_valid_q, m_unique_q;
  logic [IDX_W-1:0]     m_idx_q;
  logic [SCORE_W-1:0]   m_best_q, m_second_q;

  assign accept_s     = s_valid && s_ready_q;
  assign last_beat_s  = (beat_cnt_q == BEAT_W'(NBEATS - 1));
  assign first_beat_s = (beat_cnt_q == BEAT_W'(0));
  // Beat 0 reduces with the live mode; later beats use the value sampled then.
  assign mode_eff_s   = first_beat_s ? mode_min : mode_q;

  // Stage A combinational reduction of one beat to best/second/index.
  always_comb begin
    base_s = IDX_W'(beat_cnt_q) * IDX_W'(LANES);
    lane_s = s_scores[0 +: SCORE_W];
    bb_s   = lane_s;
    bi_s   = base_s;
    bs_s   = mode_eff_s ? {SCORE_W{1'b1}} : {SCORE_W{1'b0}};
    for (int j = 1; j < LANES; j++) begin
      lane_s = s_scores[j*SCORE_W +: SCORE_W];
      if (better(lane_s, bb_s, mode_eff_s)) begin
        bs_s = bb_s;
        bb_s = lane_s;
        bi_s = base_s + IDX_W'(j);
      end else begin
        bs_s = pick(bs_s, lane_s, mode_eff_s);
      end
    end
  end

  // Beat counter and per-pixel sampling of mode and margin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= BEAT_W'(0);
      mode_q     <= 1'b0;
      margin_q   <= {SCORE_W{1'b0}};
    end else if (accept_s) begin
      beat_cnt_q <= last_beat_s ? BEAT_W'(0) : beat_cnt_q + BEAT_W'(1);
      if (first_beat_s) begin
        mode_q   <= mode_min;
        margin_q <= uniq_margin;
      end
    end
  end

  // Stage A register: per-beat best/second with position flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld_q   <= 1'b0;
      a_first_q <= 1'b0;
      a_last_q  <= 1'b0;
      a_best_q  <= {SCORE_W{1'b0}};
      a_sec_q   <= {SCORE_W{1'b0}};
      a_idx_q   <= {IDX_W{1'b0}};
    end else begin
      a_vld_q <= accept_s;
      if (accept_s) begin
        a_first_q <= first_beat_s;
        a_last_q  <= last_beat_s;
        a_best_q  <= bb_s;
        a_sec_q   <= bs_s;
        a_idx_q   <= bi_s;
      end
    end
  end

  // Stage B merge of the beat result into the running accumulator.
  always_comb begin
    nb_s = acc_best_q;
    ni_s = acc_idx_q;
    ns_s = acc_sec_q;
    if (a_first_q) begin
      nb_s = a_best_q;
      ni_s = a_idx_q;
      ns_s = a_sec_q;
    end else if (better(a_best_q, acc_best_q, mode_q)) begin
      nb_s = a_best_q;
      ni_s = a_idx_q;
      ns_s = pick(acc_best_q, a_sec_q, mode_q);
    end else begin
      ns_s = pick(acc_sec_q, a_best_q, mode_q);
    end
  end

  // Stage B register: accumulator plus marker that the last beat has merged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_best_q <= {SCORE_W{1'b0}};
      acc_sec_q  <= {SCORE_W{1'b0}};
      acc_idx_q  <= {IDX_W{1'b0}};
      b_last_q   <= 1'b0;
    end else begin
      b_last_q <= a_vld_q && a_last_q;
      if (a_vld_q) begin
        acc_best_q <= nb_s;
        acc_sec_q  <= ns_s;
        acc_idx_q  <= ni_s;
      end
    end
  end

  // Margin between best and second, one extra bit so it never wraps.
  always_comb begin
    if (mode_q) diff_s = {1'b0, acc_sec_q} - {1'b0, acc_best_q};
    else        diff_s = {1'b0, acc_best_q} - {1'b0, acc_sec_q};
    uniq_s = (diff_s >= {1'b0, margin_q});
  end

  // Output registers: load when the final merge is done, drop on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q  <= 1'b0;
      m_idx_q    <= {IDX_W{1'b0}};
      m_best_q   <= {SCORE_W{1'b0}};
      m_second_q <= {SCORE_W{1'b0}};
      m_unique_q <= 1'b0;
    end else if (b_last_q) begin
      m_valid_q  <= 1'b1;
      m_idx_q    <= acc_idx_q;
      m_best_q   <= acc_best_q;
      m_second_q <= acc_sec_q;
      m_unique_q <= uniq_s;
    end else if (m_valid_q && m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept_s && last_beat_s) state_d = ST_DRAIN;
        else                         state_d = ST_ACCUM;
      end
      ST_DRAIN: state_d = ST_HOLD;
      ST_HOLD: begin
        if (m_valid_q && m_ready) state_d = ST_ACCUM;
        else                      state_d = ST_HOLD;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // FSM state register; s_ready is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACCUM;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d == ST_ACCUM);
    end
  end

  assign s_ready  = s_ready_q;
  assign m_valid  = m_valid_q;
  assign m_idx    = m_idx_q;
  assign m_best   = m_best_q;
  assign m_second = m_second_q;
  assign m_unique = m_unique_q;

endmodule

// File: tb/tb_disparity_argbest.sv
// Self-checking bench for disparity_argbest: directed and randomized pixels
// compared against a plain arithmetic arg-best model.
module tb_disparity_argbest;

  localparam int SCORE_W = 18;
  localparam int LANES   = 4;
  localparam int NCAND   = 16;
  localparam int IDX_W   = 6;
  localparam int NBEATS  = NCAND / LANES;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     mode_min;
  logic [SCORE_W-1:0]       uniq_margin;
  logic                     s_valid;
  logic                     s_ready;
  logic [LANES*SCORE_W-1:0] s_scores;
  logic                     m_valid;
  logic                     m_ready;
  logic [IDX_W-1:0]         m_idx;
  logic [SCORE_W-1:0]       m_best;
  logic [SCORE_W-1:0]       m_second;
  logic                     m_unique;

  int errors = 0;
  int checks = 0;
  logic [SCORE_W-1:0] pix [NCAND];

  disparity_argbest #(.SCORE_W(SCORE_W), .LANES(LANES), .NCAND(NCAND), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode_min(mode_min), .uniq_margin(uniq_margin),
    .s_valid(s_valid), .s_ready(s_ready), .s_scores(s_scores),
    .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx), .m_best(m_best),
    .m_second(m_second), .m_unique(m_unique)
  );

  always #5 clk = ~clk;

  // Reference: best = first index holding the extreme value, second = extreme of the rest.
  task automatic model(input bit mmin, input logic [SCORE_W-1:0] margin,
                       output logic [IDX_W-1:0] ei, output logic [SCORE_W-1:0] eb,
                       output logic [SCORE_W-1:0] es, output bit eu);
    int bi;
    int sec;
    int diff;
    bit have;
    bi = 0;
    for (int i = 1; i < NCAND; i++)
      if (mmin ? (pix[i] < pix[bi]) : (pix[i] > pix[bi])) bi = i;
    have = 1'b0;
    sec  = 0;
    for (int i = 0; i < NCAND; i++) begin
      if (i != bi) begin
        if (!have || (mmin ? (int'(pix[i]) < sec) : (int'(pix[i]) > sec))) sec = int'(pix[i]);
        have = 1'b1;
      end
    end
    diff = mmin ? (sec - int'(pix[bi])) : (int'(pix[bi]) - sec);
    ei = IDX_W'(bi);
    eb = pix[bi];
    es = SCORE_W'(sec);
    eu = (diff >= int'(margin));
  endtask

  // Drive beats first..last of pix[]; optional random gaps and mid-pixel control changes.
  task automatic send_beats(input int first, input int last, input bit mmin,
                            input logic [SCORE_W-1:0] margin, input int max_gap, input bit toggle);
    int gap;
    int t;
    for (int b = first; b <= last; b++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        s_valid  = 1'b0;
        s_scores = {$urandom, $urandom, $urandom};
        if (toggle && b > 0) mode_min = ~mode_min;
      end
      @(negedge clk);
      s_valid = 1'b1;
      for (int j = 0; j < LANES; j++) s_scores[j*SCORE_W +: SCORE_W] = pix[b*LANES + j];
      if (b == 0) begin
        mode_min    = mmin;
        uniq_margin = margin;
      end else if (toggle) begin
        mode_min    = ~mode_min;
        uniq_margin = SCORE_W'($urandom);
      end
      t = 0;
      while (!s_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!s_ready) begin
        checks++; errors++;
        $display("FAIL accept_timeout beat=%0d s_ready=%b required 1", b, s_ready);
      end
      @(posedge clk);
    end
  endtask

  // Check latency after the final accept and the result, then consume after `hold` cycles.
  task automatic check_result(input string name, input bit mmin,
                              input logic [SCORE_W-1:0] margin, input int hold);
    logic [IDX_W-1:0]   ei;
    logic [SCORE_W-1:0] eb, es;
    bit                 eu;
    model(mmin, margin, ei, eb, es, eu);
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_E s_ready=%b m_valid=%b required 0 0", name, s_ready, m_valid);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early_valid m_valid=%b required 0", name, m_valid);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency m_valid=%b required 1", name, m_valid);
    end
    checks++;
    if (m_idx !== ei || m_best !== eb || m_second !== es || m_unique !== eu) begin
      errors++;
      $display("FAIL %s_result idx=%0d best=%0d second=%0d uniq=%b required %0d %0d %0d %b",
               name, m_idx, m_best, m_second, m_unique, ei, eb, es, eu);
    end
    for (int k = 0; k < hold; k++) begin
      s_valid  = 1'($urandom);
      s_scores = {$urandom, $urandom, $urandom};
      m_ready  = 1'b0;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_idx !== ei || m_best !== eb ||
          m_second !== es || m_unique !== eu) begin
        errors++;
        $display("FAIL %s_hold cyc=%0d valid=%b s_ready=%b idx=%0d best=%0d second=%0d required 1 0 %0d %0d %0d",
                 name, k, m_valid, s_ready, m_idx, m_best, m_second, ei, eb, es);
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_consume m_valid=%b s_ready=%b required 0 1", name, m_valid, s_ready);
    end
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_idx !== '0 || m_best !== '0 ||
        m_second !== '0 || m_unique !== 1'b0) begin
      errors++;
      $display("FAIL %s valid=%b s_ready=%b idx=%0d best=%0d second=%0d uniq=%b required 0 1 0 0 0 0",
               name, m_valid, s_ready, m_idx, m_best, m_second, m_unique);
    end
  endtask

  task automatic test_reset;
    s_valid = 1'b0; m_ready = 1'b0; mode_min = 1'b0; uniq_margin = '0; s_scores = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_state("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ramp_max;
    for (int i = 0; i < NCAND; i++) pix[i] = SCORE_W'(10 * i);
    send_beats(0, NBEATS - 1, 1'b0, 18'd5, 0, 1'b0);
    check_result("ramp_max", 1'b0, 18'd5, 0);
  endtask

  task automatic test_tie_max;
    for (int i = 0; i < NCAND; i++) pix[i] = '0;
    pix[3] = 18'd200; pix[9] = 18'd200;
    send_beats(0, NBEATS - 1, 1'b0, 18'd1, 0, 1'b0);
    check_result("tie_max", 1'b0, 18'd1, 0);
  endtask

  task automatic test_min_boundary;
    for (int i = 0; i < NCAND; i++) pix[i] = SCORE_W'(10 * i);
    send_beats(0, NBEATS - 1, 1'b1, 18'd10, 0, 1'b0);
    check_result("min_margin10", 1'b1, 18'd10, 0);
    send_beats(0, NBEATS - 1, 1'b1, 18'd11, 0, 1'b0);
    check_result("min_margin11", 1'b1, 18'd11, 0);
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < NCAND; i++) pix[i] = SCORE_W'($urandom_range(0, 1000));
    send_beats(0, NBEATS - 1, 1'b0, 18'd3, 0, 1'b0);
    check_result("hold5", 1'b0, 18'd3, 5);
    for (int i = 0; i < NCAND; i++) pix[i] = SCORE_W'($urandom_range(0, 1000));
    send_beats(0, NBEATS - 1, 1'b1, 18'd2, 0, 1'b0);
    check_result("after_hold", 1'b1, 18'd2, 0);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < NCAND; i++) pix[i] = SCORE_W'(1000 - i);
    send_beats(0, 1, 1'b1, 18'd0, 0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset_mid_pixel");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NCAND; i++) pix[i] = SCORE_W'($urandom_range(0, 500));
    send_beats(0, NBEATS - 1, 1'b0, 18'd4, 0, 1'b0);
    check_result("fresh_after_reset", 1'b0, 18'd4, 0);
  endtask

  task automatic test_reset_in_hold;
    for (int i = 0; i < NCAND; i++) pix[i] = SCORE_W'(i + 7);
    send_beats(0, NBEATS - 1, 1'b0, 18'd0, 0, 1'b0);
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset_in_hold");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_gaps_toggle;
    bit mm;
    logic [SCORE_W-1:0] mg;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NCAND; i++) pix[i] = SCORE_W'($urandom_range(0, 300));
      mm = 1'($urandom);
      mg = SCORE_W'($urandom_range(0, 40));
      send_beats(0, NBEATS - 1, mm, mg, 3, 1'b1);
      check_result("gaps_toggle", mm, mg, 0);
      send_beats(0, NBEATS - 1, mm, mg, 0, 1'b0);
      check_result("gap_free_ref", mm, mg, 0);
    end
  endtask

  task automatic test_random;
    bit mm;
    logic [SCORE_W-1:0] mg;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NCAND; i++)
        pix[i] = (n % 2 == 0) ? SCORE_W'($urandom_range(0, 7)) : SCORE_W'($urandom);
      mm = 1'($urandom);
      mg = (n % 4 == 0) ? '0 : SCORE_W'($urandom_range(0, 8));
      send_beats(0, NBEATS - 1, mm, mg, 0, 1'b0);
      check_result("random", mm, mg, n % 3);
    end
  endtask

  initial begin
    test_reset;
    test_ramp_max;
    test_tie_max;
    test_min_boundary;
    test_backpressure;
    test_reset_mid;
    test_reset_in_hold;
    test_gaps_toggle;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
